// File: rtl/program_sequencer_if.sv
// Program sequencer bus: operation request in, program address and status out.
interface program_sequencer_if #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic             enable;
  logic [2:0]       op;
  logic [WIDTH-1:0] target;
  logic             resume;
  logic [WIDTH-1:0] count;
  logic             halted;
  logic             fault;
  logic [LVL_W-1:0] stackLevel;

  modport master (
    output enable, op, target, resume,
    input  count, halted, fault, stackLevel
  );

  modport slave (
    input  enable, op, target, resume,
    output count, halted, fault, stackLevel
  );
endinterface

// File: rtl/program_sequencer.sv
// Program address sequencer: next/relative/absolute jumps, call/return stack,
// halt with resume, and a sticky fault on stack over/underflow.
module program_sequencer #(
  parameter int               WIDTH       = 8,
  parameter int               STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] START_ADDR  = '0
) (
  input logic                clk,
  input logic                reset,
  program_sequencer_if.slave bus
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(STACK_DEPTH);

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JREL = 3'd1;
  localparam logic [2:0] OP_JABS = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;

  state_t           state, nxt_state;
  logic [WIDTH-1:0] count, nxt_count;
  logic [LVL_W-1:0] level, nxt_level;
  logic             push;
  logic [WIDTH-1:0] stack [STACK_DEPTH];

  logic [LVL_W-1:0] level_m1;
  logic [PTR_W-1:0] push_idx, top_idx;
  logic [WIDTH-1:0] ret_addr;

  // Push goes to slot [level], pop reads slot [level-1]; only used when in range.
  assign level_m1 = level - 1'b1;
  assign push_idx = level[PTR_W-1:0];
  assign top_idx  = level_m1[PTR_W-1:0];
  assign ret_addr = count + 1'b1;

  // State, address and stack level; reset returns to RUN at START_ADDR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      count <= START_ADDR;
      level <= '0;
    end else begin
      state <= nxt_state;
      count <= nxt_count;
      level <= nxt_level;
    end
  end

  // Stack storage needs no reset: level alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push) stack[push_idx] <= ret_addr;
  end

  // Next-state and next-address decode; enable=0 freezes everything.
  always_comb begin
    nxt_state = state;
    nxt_count = count;
    nxt_level = level;
    push      = 1'b0;
    if (bus.enable) begin
      unique case (state)
        RUN: begin
          case (bus.op)
            OP_JREL: nxt_count = count + bus.target;  // two's-complement wrap
            OP_JABS: nxt_count = bus.target;
            OP_CALL: begin
              if (level == LVL_FULL) nxt_state = FAULT;
              else begin
                push      = 1'b1;
                nxt_count = bus.target;
                nxt_level = level + 1'b1;
              end
            end
            OP_RET: begin
              if (level == '0) nxt_state = FAULT;
              else begin
                nxt_count = stack[top_idx];
                nxt_level = level_m1;
              end
            end
            OP_HALT: nxt_state = HALTED;
            default: nxt_count = count + 1'b1;  // NEXT and reserved codes
          endcase
        end
        HALTED: if (bus.resume) nxt_state = RUN;
        FAULT:  nxt_state = FAULT;
        default: nxt_state = FAULT;
      endcase
    end
  end

  assign bus.count      = count;
  assign bus.halted     = (state == HALTED);
  assign bus.fault      = (state == FAULT);
  assign bus.stackLevel = level;
endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, width of the program address.
REQ-002 Parameter STACK_DEPTH, default 4, number of return-address entries (>=1).
REQ-003 Parameter START_ADDR, default 0, address loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  when 0, all state holds.
REQ-007 op  input  3  operation: 0 NEXT, 1 JREL, 2 JABS, 3 CALL, 4 RET, 5 HALT, 6-7 reserved.
REQ-008 target  input  WIDTH  jump operand; signed two's-complement for JREL, unsigned address otherwise.
REQ-009 resume  input  1  leave HALTED state.
REQ-010 count  output  WIDTH  current program address (registered).
REQ-011 halted  output  1  high while in HALTED.
REQ-012 fault  output  1  high while in FAULT.
REQ-013 stackLevel  output  clog2(STACK_DEPTH+1)  number of valid stack entries.

Function
REQ-014 The sequencer SHALL implement states RUN, HALTED, FAULT; halted/fault SHALL be decoded from state only.
REQ-015 In RUN with enable=1, the next count SHALL be: NEXT count+1; JREL count+target (signed); JABS target; CALL target; RET top-of-stack; HALT count (unchanged).
REQ-016 All address arithmetic SHALL be modulo 2^WIDTH; no carry or overflow indication.
REQ-017 CALL SHALL push count+1 (mod 2^WIDTH) and increment stackLevel in the same cycle count is loaded.
REQ-018 RET SHALL pop the top entry and decrement stackLevel in the same cycle.
REQ-019 Reserved op codes 6-7 SHALL behave as NEXT.
REQ-020 HALT SHALL move RUN->HALTED at the edge; count holds.
REQ-021 In HALTED, count and stack SHALL hold regardless of op; resume=1 with enable=1 SHALL move to RUN, count unchanged; op is ignored that cycle.
REQ-022 CALL with stackLevel=STACK_DEPTH SHALL move to FAULT; count and stack unchanged.
REQ-023 RET with stackLevel=0 SHALL move to FAULT; count unchanged.
REQ-024 FAULT SHALL be exited only by reset; count, stack, stackLevel hold; resume ignored.
REQ-025 enable=0 SHALL suppress all transitions, including resume and fault detection.
REQ-026 Result latency SHALL be one cycle: op sampled at edge N is reflected on count after edge N.

Reset
REQ-027 While reset=0, count SHALL be START_ADDR, state RUN, halted=0, fault=0, stackLevel=0, asynchronously and independent of clk.
REQ-028 Reset asserted mid-operation (any state, including FAULT) SHALL take effect immediately; stack contents need not be cleared, but stackLevel SHALL be 0.
REQ-029 First op SHALL be applied on the first rising edge after reset deasserts.

Verification (WIDTH=8, STACK_DEPTH=4, START_ADDR=0)
REQ-030 Reset, then 5 cycles NEXT -> count 5; JREL target=4 -> 9; JREL target=8'hFC -> 5.
REQ-031 JABS 8'hFE, NEXT, NEXT -> count 8'hFE, 8'hFF, 8'h00 (wrap); JREL 8'hFF from 0 -> 8'hFF.
REQ-032 At count 8'h10, CALL 8'h40 -> count 8'h40, stackLevel 1; CALL 8'h80 -> 8'h80, level 2; RET -> 8'h41, level 1; RET -> 8'h11, level 0.
REQ-033 Five consecutive CALLs from count 0 -> fifth sets fault=1, stackLevel stays 4, count holds; RET and resume afterwards change nothing; reset clears fault, count 0.
REQ-034 RET at stackLevel 0 from count 7 -> fault=1, count 7; enable=0 with RET at level 0 -> no fault.
REQ-035 At count 8'h20 HALT -> halted=1, count 8'h20 held over 10 cycles of NEXT; resume=1 -> halted=0, count 8'h20; NEXT -> 8'h21; reset pulse mid-HALTED -> count 0, halted=0 immediately.
